bcd_serial_addsub: RTL

//  Digit-serial, parametrised N-digit packed-BCD adder/subtractor with start/done handshake.

---
 rtl/bcd_serial_addsub.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD adder/subtractor, one digit per clock
// Optional operand digit check: define BCD_ADDSUB_DIGIT_CHECK_EN.
module bcd_serial_addsub #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   S,
  output logic                  Cout,
  output logic                  neg,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS1,
    ST_PASS2,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_work;
  logic            r_mode;
  logic            r_carry;
  logic            r_c1;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;

  logic [3:0]      w_x;
  logic [3:0]      w_y;
  logic [4:0]      w_sum;
  logic            w_dc;
  logic [3:0]      w_digit;
  logic            w_last;
  logic            w_force_zero;

  // Shared digit adder: PASS1 adds A and B (or 9's complement of B), PASS2 complements the result.
  always_comb begin
    w_x = r_a[3:0];
    w_y = r_mode ? (4'd9 - r_b[3:0]) : r_b[3:0];
    if (r_state == ST_PASS2) begin
      w_x = 4'd9 - r_work[3:0];
      w_y = 4'd0;
    end
  end

  assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_carry};
  assign w_dc    = (w_sum > 5'd9);
  assign w_digit = w_dc ? (w_sum[3:0] + 4'd6) : w_sum[3:0];
  assign w_last  = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_PASS1;
      ST_PASS1: if (w_last) w_next = (r_mode && !w_dc) ? ST_PASS2 : ST_DONE;
      ST_PASS2: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_c1    <= 1'b0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_mode  <= mode;
            r_carry <= mode;
            r_cnt   <= '0;
            r_work  <= '0;
            r_neg   <= 1'b0;
            r_c1    <= 1'b0;
            busy    <= 1'b1;
          end
        end
        ST_PASS1: begin
          r_work  <= {w_digit, r_work[W-1:4]};
          r_a     <= {4'd0, r_a[W-1:4]};
          r_b     <= {4'd0, r_b[W-1:4]};
          r_carry <= w_dc;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_c1 <= w_dc;
            // A borrow out of a subtraction means A<B: second pass starts with carry-in 1.
            if (r_mode && !w_dc) begin
              r_neg   <= 1'b1;
              r_carry <= 1'b1;
            end
          end
        end
        ST_PASS2: begin
          r_work  <= {w_digit, r_work[W-1:4]};
          r_carry <= w_dc;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          S    <= w_force_zero ? '0 : r_work;
          Cout <= r_c1;
          neg  <= r_neg;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_ADDSUB_DIGIT_CHECK_EN
  logic r_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start)
        r_bad <= 1'b0;
      else if (r_state == ST_PASS1 && (r_a[3:0] > 4'd9 || r_b[3:0] > 4'd9))
        r_bad <= 1'b1;
      if (r_state == ST_DONE)
        err <= r_bad;
    end
  end

  assign w_force_zero = r_bad;
`else
  assign err          = 1'b0;
  assign w_force_zero = 1'b0;
`endif

endmodule
